// File: rtl/ccff_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_pkg;

    // Loader sequencing: isolate the I/O, shift the chain, guard, then release.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        SHIFT   = 2'd2,
        RELEASE = 2'd3
    } ccff_ld_state_t;

    // Bits needed to hold any count from 0 up to and including max_val.
    function automatic int ccff_cnt_w(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: holds one configuration word and presents it LSB
// first. A new word may be loaded in the same cycle the last held bit leaves,
// so a continuous source sees no bubble between words.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int LEN_W  = ccff_cnt_w(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    input  logic [LEN_W-1:0]  i_load_len,   // bits of the offered word that will be used
    input  logic              i_allow_nxt,  // loader will still want words next cycle
    output logic              o_accept,     // word taken on the coming edge
    output logic              o_ready,
    output logic              o_bit,
    output logic              o_shift
);

    logic [WORD_W-1:0] r_sreg;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_ready;
    logic              r_shift;
    logic [WORD_W-1:0] w_sreg_nxt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic              w_accept;

    // Next contents of the shift register: load a word, shift one bit, or hold.
    always_comb begin
        w_accept   = i_valid & r_ready;
        w_sreg_nxt = r_sreg;
        w_cnt_nxt  = r_cnt;
        if (w_accept) begin
            w_sreg_nxt = i_data;
            w_cnt_nxt  = i_load_len;
        end else if (r_cnt != {LEN_W{1'b0}}) begin
            // Clear once the last useful bit leaves so truncated word bits never reach the head.
            if (r_cnt == LEN_W'(1)) begin
                w_sreg_nxt = {WORD_W{1'b0}};
            end else begin
                w_sreg_nxt = r_sreg >> 1;
            end
            w_cnt_nxt = r_cnt - LEN_W'(1);
        end else begin
            w_sreg_nxt = r_sreg;
            w_cnt_nxt  = r_cnt;
        end
    end

    // Register the word, its remaining-bit count and the derived ready/shift flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg  <= {WORD_W{1'b0}};
            r_cnt   <= {LEN_W{1'b0}};
            r_ready <= 1'b0;
            r_shift <= 1'b0;
        end else begin
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= (w_cnt_nxt != {LEN_W{1'b0}});
            // Ready when empty or when the single remaining bit shifts out next cycle.
            r_ready <= i_allow_nxt && (w_cnt_nxt <= LEN_W'(1));
        end
    end

    assign o_accept = w_accept;
    assign o_ready  = r_ready;
    assign o_bit    = r_sreg[0];
    assign o_shift  = r_shift;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: isolates the I/O, streams CHAIN_LEN bits LSB
// first into ccff_head, counts ones returning on ccff_tail, then releases.
//
// Load duration with s_valid already high: if start is sampled at edge S,
// done is high in the single cycle following edge S + 2*ISO_CYC + CHAIN_LEN + 1
// (ISO_CYC isolate cycles, one cycle to take the first word, CHAIN_LEN shift
// cycles, ISO_CYC release cycles).
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int ISO_CYC   = 4
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic [WORD_W-1:0]              s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           IO_ISOL_N,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] tail_ones
);

    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int GRD_W = ccff_cnt_w(ISO_CYC);
    localparam int LEN_W = ccff_cnt_w(WORD_W);

    localparam logic [BIT_W-1:0] CHAIN_LEN_B = BIT_W'(CHAIN_LEN);
    localparam logic [GRD_W-1:0] ISO_B       = GRD_W'(ISO_CYC);
    localparam logic [LEN_W-1:0] WORD_L      = LEN_W'(WORD_W);

    ccff_ld_state_t   r_state;
    logic [GRD_W-1:0] r_grd;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] r_loaded;
    logic [BIT_W-1:0] r_tail_ones;
    logic             r_isol_n;
    logic             r_busy;
    logic             r_done;

    ccff_ld_state_t   w_state_nxt;
    logic [GRD_W-1:0] w_grd_nxt;
    logic [BIT_W-1:0] w_bit_cnt_nxt;
    logic [BIT_W-1:0] w_loaded_nxt;
    logic [BIT_W-1:0] w_tail_nxt;
    logic [BIT_W-1:0] w_remain;
    logic [LEN_W-1:0] w_load_len;
    logic             w_done_nxt;
    logic             w_allow_nxt;
    logic             w_accept;
    logic             w_shift;
    logic             w_head;
    logic             w_ready;

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_ser (
        .clk         (prog_clk),
        .rst         (pReset),
        .i_data      (s_data),
        .i_valid     (s_valid),
        .i_load_len  (w_load_len),
        .i_allow_nxt (w_allow_nxt),
        .o_accept    (w_accept),
        .o_ready     (w_ready),
        .o_bit       (w_head),
        .o_shift     (w_shift)
    );

    // Size of the next word: the final word is trimmed to the bits the chain still needs.
    always_comb begin
        w_remain = CHAIN_LEN_B - r_loaded;
        if (32'(w_remain) < 32'(WORD_W)) begin
            w_load_len = LEN_W'(w_remain);
        end else begin
            w_load_len = WORD_L;
        end
    end

    // Next-state, guard/bit counters and tail checksum.
    always_comb begin
        w_state_nxt   = r_state;
        w_grd_nxt     = r_grd;
        w_bit_cnt_nxt = r_bit_cnt;
        w_loaded_nxt  = r_loaded;
        w_tail_nxt    = r_tail_ones;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = ISOLATE;
                    w_grd_nxt     = ISO_B;
                    w_bit_cnt_nxt = {BIT_W{1'b0}};
                    w_loaded_nxt  = {BIT_W{1'b0}};
                    w_tail_nxt    = {BIT_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISOLATE: begin
                if (r_grd <= GRD_W'(1)) begin
                    w_state_nxt = SHIFT;
                    w_grd_nxt   = {GRD_W{1'b0}};
                end else begin
                    w_grd_nxt = r_grd - GRD_W'(1);
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    w_loaded_nxt = r_loaded + BIT_W'(w_load_len);
                end else begin
                    w_loaded_nxt = r_loaded;
                end
                // The chain moves on this edge, so the tail bit now present is the one leaving.
                if (w_shift) begin
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    w_tail_nxt    = r_tail_ones + BIT_W'(ccff_tail);
                    if (w_bit_cnt_nxt == CHAIN_LEN_B) begin
                        w_state_nxt = RELEASE;
                        w_grd_nxt   = ISO_B;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt;
                end
            end
            RELEASE: begin
                if (r_grd <= GRD_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_grd_nxt   = {GRD_W{1'b0}};
                    w_done_nxt  = 1'b1;
                end else begin
                    w_grd_nxt = r_grd - GRD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_allow_nxt = (w_state_nxt == SHIFT) && (w_loaded_nxt < CHAIN_LEN_B);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state     <= IDLE;
            r_grd       <= {GRD_W{1'b0}};
            r_bit_cnt   <= {BIT_W{1'b0}};
            r_loaded    <= {BIT_W{1'b0}};
            r_tail_ones <= {BIT_W{1'b0}};
            r_isol_n    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grd       <= w_grd_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_loaded    <= w_loaded_nxt;
            r_tail_ones <= w_tail_nxt;
            r_isol_n    <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign s_ready       = w_ready;
    assign ccff_head     = w_head;
    assign ccff_shift_en = w_shift;
    assign IO_ISOL_N     = r_isol_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign tail_ones     = r_tail_ones;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a 16-bit and a 12-bit chain loader share one stimulus
// stream; each drives its own chain model that feeds ccff_tail back.
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;

    logic       rdy16, head16, sh16, iso16, busy16, done16, tail16;
    logic [4:0] ones16;
    logic       rdy12, head12, sh12, iso12, busy12, done12, tail12;
    logic [3:0] ones12;

    logic [15:0] chain16 = 16'h0000;
    logic [11:0] chain12 = 12'h000;
    logic        pre_req = 1'b0;
    logic [15:0] pre_val = 16'h0000;

    int   cyc = 0;
    logic h16[$];
    logic h12[$];
    int   done_cnt16 = 0, done_cnt12 = 0, done_cyc16 = 0, done_cyc12 = 0;
    int   acc16 = 0, acc12 = 0, viol16 = 0, viol12 = 0;
    int   n_vec = 0, n_bad = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .ISO_CYC(2)) dut16 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy16), .ccff_head(head16), .ccff_shift_en(sh16),
        .ccff_tail(tail16), .IO_ISOL_N(iso16), .busy(busy16), .done(done16),
        .tail_ones(ones16)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .ISO_CYC(2)) dut12 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy12), .ccff_head(head12), .ccff_shift_en(sh12),
        .ccff_tail(tail12), .IO_ISOL_N(iso12), .busy(busy12), .done(done12),
        .tail_ones(ones12)
    );

    assign tail16 = chain16[15];
    assign tail12 = chain12[11];

    // Chain models: shift toward the tail on enabled edges, or take a preload.
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (pre_req) chain16 <= pre_val;
        else if (sh16) chain16 <= {chain16[14:0], head16};
        if (sh12) chain12 <= {chain12[10:0], head12};
    end

    // Monitor on the falling edge: head log, done pulses, accepts, isolation breaks.
    always @(negedge prog_clk) begin
        if (sh16) h16.push_back(head16);
        if (sh12) h12.push_back(head12);
        if (done16) begin done_cnt16 <= done_cnt16 + 1; done_cyc16 <= cyc; end
        if (done12) begin done_cnt12 <= done_cnt12 + 1; done_cyc12 <= cyc; end
        if (s_valid && rdy16) acc16 <= acc16 + 1;
        if (s_valid && rdy12) acc12 <= acc12 + 1;
        if ((busy16 || sh16) && iso16) viol16 <= viol16 + 1;
        if ((busy12 || sh12) && iso12) viol12 <= viol12 + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge prog_clk);
            if (rdy16) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_out16"}, {rdy16, head16, sh16, iso16, busy16, done16, ones16},
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
        check_vec({tag, "_out12"}, {rdy12, head12, sh12, iso12, busy12, done12, ones12},
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
    endtask

    // One complete load of two words into both chains, then all per-load checks.
    task automatic run_load(input string name, input logic [7:0] w0, input logic [7:0] w1,
                            input int gap, input logic [15:0] exp_seq,
                            input int exp_lat16, input int exp_lat12,
                            input int exp_t16, input int exp_t12);
        int b16, b12, d16, d12, a16, a12, v16, v12, t0, n;
        logic [15:0] seq16;
        logic [11:0] seq12;
        logic [7:0]  w [2];
        bit ok;
        w[0] = w0;
        w[1] = w1;
        b16 = h16.size(); b12 = h12.size();
        d16 = done_cnt16; d12 = done_cnt12;
        a16 = acc16; a12 = acc12;
        v16 = viol16; v12 = viol12;
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 2; i++) begin
            s_data  = w[i];
            s_valid = 1'b1;
            wait_ready(ok);
            if (!ok) check_vec({name, "_ready_timeout"}, 32'(ok), 32'd1);
            @(posedge prog_clk); #1;
            if (gap > 0 && i == 0) begin
                s_valid = 1'b0;
                wait_ready(ok);
                if (!ok) check_vec({name, "_gap_timeout"}, 32'(ok), 32'd1);
                repeat (gap) @(posedge prog_clk);
                #1;
            end
        end
        // Keep offering a word: neither loader may take a third one.
        s_data  = 8'h00;
        s_valid = 1'b1;
        n = 0;
        while ((done_cnt16 == d16 || done_cnt12 == d12) && n < 300) begin
            @(negedge prog_clk); #1;
            n++;
        end
        if (n >= 300) check_vec({name, "_done_timeout"}, 32'(n), 32'd0);
        repeat (3) @(posedge prog_clk);
        #1 s_valid = 1'b0;
        @(negedge prog_clk); #1;
        seq16 = 16'h0000;
        for (int i = b16; i < h16.size(); i++) seq16 = {seq16[14:0], h16[i]};
        seq12 = 12'h000;
        for (int i = b12; i < h12.size(); i++) seq12 = {seq12[10:0], h12[i]};
        check_vec({name, "_seq16"}, 32'(seq16), 32'(exp_seq));
        check_vec({name, "_seq12"}, 32'(seq12), 32'(exp_seq[15:4]));
        check_vec({name, "_nshift16"}, 32'(h16.size() - b16), 32'd16);
        check_vec({name, "_nshift12"}, 32'(h12.size() - b12), 32'd12);
        check_vec({name, "_ndone16"}, 32'(done_cnt16 - d16), 32'd1);
        check_vec({name, "_ndone12"}, 32'(done_cnt12 - d12), 32'd1);
        check_vec({name, "_nacc16"}, 32'(acc16 - a16), 32'd2);
        check_vec({name, "_nacc12"}, 32'(acc12 - a12), 32'd2);
        check_vec({name, "_lat16"}, 32'(done_cyc16 - t0), 32'(exp_lat16));
        check_vec({name, "_lat12"}, 32'(done_cyc12 - t0), 32'(exp_lat12));
        check_vec({name, "_isol"}, 32'((viol16 - v16) + (viol12 - v12)), 32'd0);
        check_vec({name, "_busy_end"}, {30'd0, busy16, busy12}, 32'd0);
        if (exp_t16 >= 0) check_vec({name, "_tail16"}, 32'(ones16), 32'(exp_t16));
        if (exp_t12 >= 0) check_vec({name, "_tail12"}, 32'(ones12), 32'(exp_t12));
    endtask

    initial begin
        int n;
        pReset  = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge prog_clk);
        #1 pReset = 1'b0;
        @(negedge prog_clk);
        check_reset_outputs("reset");

        // Back-to-back words; 12-bit chain takes only the low half of 0x3C.
        run_load("t1_a5_3c", 8'hA5, 8'h3C, 0, 16'hA53C, 21, 17, 0, 0);
        check_vec("t1_chain16", 32'(chain16), 32'h0000A53C);

        // All-ones words; 12-bit chain drops bits 4-7 of the second word.
        run_load("t2_ff_ff", 8'hFF, 8'hFF, 0, 16'hFFFF, 21, 17, 8, 6);

        // Three idle cycles between words stretch the load but not the bit order.
        run_load("t3_gap", 8'hA5, 8'h3C, 3, 16'hA53C, 24, 20, 16, 12);

        // Readback checksum of a preloaded chain.
        @(posedge prog_clk); #1 pre_val = 16'h00F3; pre_req = 1'b1;
        @(posedge prog_clk); #1 pre_req = 1'b0;
        run_load("t4_tail", 8'hA5, 8'h3C, 0, 16'hA53C, 21, 17, 6, 6);
        check_vec("t4_chain16", 32'(chain16), 32'h0000A53C);

        // Reset after five bits have gone out, then a clean reload.
        n = h16.size();
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        s_data  = 8'hA5;
        s_valid = 1'b1;
        for (int k = 0; k < 100 && (h16.size() - n) < 5; k++) begin
            @(negedge prog_clk); #1;
        end
        check_vec("t5_bits_before_rst", 32'(h16.size() - n), 32'd5);
        @(posedge prog_clk); #1 pReset = 1'b1;
        @(posedge prog_clk); #1 pReset = 1'b0; s_valid = 1'b0;
        @(negedge prog_clk);
        check_reset_outputs("t5_midrst");
        run_load("t5_after_rst", 8'hA5, 8'h3C, 0, 16'hA53C, 21, 17, -1, -1);

        // Stray start pulses during ISOLATE and during SHIFT are ignored.
        fork
            run_load("t6_restart", 8'hA5, 8'h3C, 0, 16'hA53C, 21, 17, 8, 6);
            begin
                repeat (2) @(posedge prog_clk);
                #2 start = 1'b1;
                @(posedge prog_clk); #1 start = 1'b0;
                repeat (5) @(posedge prog_clk);
                #2 start = 1'b1;
                @(posedge prog_clk); #1 start = 1'b0;
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader for the I/O and logic tiles. It accepts configuration words from the bitstream source over a valid/ready stream and serializes them LSB-first onto the configuration flip-flop chain through `ccff_head`. It emits a per-bit shift enable that gates `prog_clk` to the chain, and holds `IO_ISOL_N` low (isolated) around programming. While loading, it counts the ones leaving `ccff_tail`, giving a readback checksum of the previous configuration. It sits between the programming interface and the first tile's `ccff_head`, with the last tile's `ccff_tail` returned to it.

## Interface
- `CHAIN_LEN`, default 64: total configuration bits in the chain (≥1).
- `WORD_W`, default 8: input word width (≥1).
- `ISO_CYC`, default 4: isolation guard cycles before shifting and before release (≥1).
- `prog_clk` in 1: the single clock, rising edge.
- `pReset` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle request to begin a load.
- `s_data` in `WORD_W`: configuration word, bit 0 shifted first.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader accepts `s_data` this cycle.
- `ccff_head` out 1: serial bit into the chain.
- `ccff_shift_en` out 1: chain clock enable; the chain shifts on each `prog_clk` edge where it is high.
- `ccff_tail` in 1: serial bit out of the chain.
- `IO_ISOL_N` out 1: I/O isolation, low means isolated.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on return to IDLE after a completed load.
- `tail_ones` out `$clog2(CHAIN_LEN+1)`: count of ones sampled from `ccff_tail` during the last load.

## Operation
- **States:** IDLE → ISOLATE → SHIFT → RELEASE → IDLE.
- **IDLE**
  - `IO_ISOL_N`=1, `s_ready`=0.
  - `start`=1 → ISOLATE; clears `tail_ones` and the bit counter, loads the guard counter with `ISO_CYC`.
- **ISOLATE**
  - `IO_ISOL_N`=0.
  - Guard counter decrements each cycle; it spends exactly `ISO_CYC` cycles here, then → SHIFT.
- **SHIFT**
  - `IO_ISOL_N`=0.
  - Holds a `WORD_W`-bit shift register plus a remaining-bits count.
  - `s_ready`=1 when the register is empty, or holds exactly one bit that is being shifted this cycle. This allows back-to-back words with no bubble.
  - Each cycle the register holds a bit: drive that bit on `ccff_head` with `ccff_shift_en`=1, sample `ccff_tail` (add it to `tail_ones`), and increment the chain bit counter.
  - When the register is empty and `s_valid`=0: `ccff_shift_en`=0 and the chain holds.
  - Words accepted per load = ceil(`CHAIN_LEN`/`WORD_W`). Bits of the final word beyond `CHAIN_LEN` are discarded and never shifted. No further words are accepted after the last one.
  - When bit counter = `CHAIN_LEN` → RELEASE; reload the guard counter.
- **RELEASE**
  - `IO_ISOL_N`=0, `ccff_shift_en`=0.
  - Spends `ISO_CYC` cycles here, then → IDLE with `done`=1 for that one cycle.
- **Boundary conditions**
  - `start` while `busy` is ignored.
  - `s_valid` outside SHIFT is ignored (`s_ready`=0).
  - `pReset` mid-load: all state returns to reset values immediately. The chain contents are then undefined and the host must restart.
  - The first bit shifted ends at the chain's tail end after `CHAIN_LEN` shifts.

## Timing
- **Reset values:** state=IDLE, `s_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `IO_ISOL_N`=1, `busy`=0, `done`=0, `tail_ones`=0.
- **Outputs:** all outputs are registered. `ccff_head` and `ccff_shift_en` change on the same edge.
- **Shift latency:** a word accepted at edge N drives its bit 0 with `ccff_shift_en`=1 in the cycle after edge N.
- **Tail sampling:** `ccff_tail` is sampled on the edge that ends a cycle with `ccff_shift_en`=1.
- **Total load duration:** with continuous `s_valid`, `start` to `done` = 1 + `ISO_CYC` + `CHAIN_LEN` + 1 + `ISO_CYC` cycles, ±1 for the registered-output alignment. The implementation fixes the exact figure and documents it in RTL comments.
- **Throughput:** one chain bit per cycle.

## Structure
- Shared package `ccff_pkg`: state enum `ccff_ld_state_t` (IDLE, ISOLATE, SHIFT, RELEASE) and width helper functions for the counters.
- One natural sub-module, `ccff_word_serializer`: the `WORD_W` shift register with its valid count and ready logic. The FSM, counters and isolation control stay in the top module.

## Test plan
1. `CHAIN_LEN`=16, `WORD_W`=8, `ISO_CYC`=2; `start`, words 0xA5 then 0x3C with `s_valid` held high → `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; exactly 16 `ccff_shift_en` cycles; `IO_ISOL_N` low throughout; `done` pulses once.
2. `CHAIN_LEN`=12, `WORD_W`=8; words 0xFF, 0xFF → 12 shifts; bits 4–7 of the second word are never shifted; `s_ready` stays 0 after the second word is accepted.
3. Gaps in `s_valid` (3 idle cycles between words) → `ccff_shift_en`=0 during the gaps, and the `ccff_head` bit sequence is unchanged from the no-gap case.
4. Chain model preloaded with 0x00F3 (6 ones), then a load of 16 bits → `tail_ones`=6 after `done`.
5. `pReset` asserted mid-SHIFT after 5 bits → next cycle all outputs at reset values, `IO_ISOL_N`=1; a new `start` then completes a full load correctly.
6. `start` pulsed during ISOLATE and during SHIFT → ignored; exactly one `done`, and no extra words accepted.
